plane_ctrl: RTL



---
 rtl/plane_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/plane_ctrl.sv
// plane_ctrl: player plane position register and rate-limited fire request.
// Position moves one STEP per enabled frame tick with saturating clamps;
// fire requests leave over a valid/ready handshake followed by a frame cooldown.
module plane_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PLANE_W  = 32,
    parameter int PLANE_H  = 32,
    parameter int STEP     = 4,
    parameter int FIRE_CD  = 8,
    parameter int CD_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       frame_tick_i,
    input  logic       btn_c_i,
    input  logic       btn_u_i,
    input  logic       btn_d_i,
    input  logic       btn_l_i,
    input  logic       btn_r_i,
    output logic [9:0] plane_x_o,
    output logic [9:0] plane_y_o,
    output logic       fire_valid_o,
    input  logic       fire_ready_i,
    output logic [9:0] fire_x_o,
    output logic [9:0] fire_y_o
);

    localparam int XMAX = SCREEN_W - PLANE_W;
    localparam int YMAX = SCREEN_H - PLANE_H;

    // 11-bit constants so clamp arithmetic never wraps
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] XMAX_W = 11'(XMAX);
    localparam logic [10:0] YMAX_W = 11'(YMAX);
    localparam logic [10:0] HALF_W = 11'(PLANE_W / 2);
    localparam logic [9:0]  X_RST  = 10'(XMAX / 2);
    localparam logic [9:0]  Y_RST  = 10'(YMAX - 8);

    typedef enum logic [1:0] {IDLE, REQ, COOL} state_t;

    state_t          state, state_nxt;
    logic [CD_W-1:0] cd, cd_nxt;
    logic [9:0]      x, y, x_nxt, y_nxt;
    logic [9:0]      fx, fy, fx_nxt, fy_nxt;
    logic [10:0]     x_w, y_w, x_dec, x_inc, y_dec, y_inc;
    logic            adv;

    assign adv   = frame_tick_i & en_i;
    assign x_w   = {1'b0, x};
    assign y_w   = {1'b0, y};
    assign x_dec = x_w - STEP_W;
    assign x_inc = x_w + STEP_W;
    assign y_dec = y_w - STEP_W;
    assign y_inc = y_w + STEP_W;

    // Next position: each axis moves only when exactly one of its buttons is held
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (adv) begin
            if (btn_l_i && !btn_r_i)
                x_nxt = (x_w < STEP_W) ? 10'd0 : x_dec[9:0];
            else if (btn_r_i && !btn_l_i)
                x_nxt = (x_w > XMAX_W - STEP_W) ? XMAX_W[9:0] : x_inc[9:0];
            if (btn_u_i && !btn_d_i)
                y_nxt = (y_w < STEP_W) ? 10'd0 : y_dec[9:0];
            else if (btn_d_i && !btn_u_i)
                y_nxt = (y_w > YMAX_W - STEP_W) ? YMAX_W[9:0] : y_inc[9:0];
        end
    end

    // Fire FSM next state; spawn coordinates use the pre-move position
    always_comb begin
        state_nxt = state;
        cd_nxt    = cd;
        fx_nxt    = fx;
        fy_nxt    = fy;
        case (state)
            IDLE: if (adv && btn_c_i) begin
                state_nxt = REQ;
                fx_nxt    = 10'(x_w + HALF_W);
                fy_nxt    = y;
            end
            // A posted request is held until accepted, regardless of en/button
            REQ: if (fire_ready_i) begin
                state_nxt = COOL;
                cd_nxt    = CD_W'(FIRE_CD);
            end
            // The tick ending cooldown cannot also start a shot
            COOL: if (adv) begin
                cd_nxt = cd - 1'b1;
                if (cd <= CD_W'(1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cd    <= '0;
            x     <= X_RST;
            y     <= Y_RST;
            fx    <= '0;
            fy    <= '0;
        end else begin
            state <= state_nxt;
            cd    <= cd_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            fx    <= fx_nxt;
            fy    <= fy_nxt;
        end
    end

    assign plane_x_o    = x;
    assign plane_y_o    = y;
    assign fire_valid_o = (state == REQ);
    assign fire_x_o     = fx;
    assign fire_y_o     = fy;

endmodule
